// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared types and constants for the AHB-Lite to APB bridge
package ahb_apb_pkg;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WWAIT   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_WENABLE = 3'd3,
        ST_READ    = 3'd4,
        ST_RENABLE = 3'd5
    } state_t;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB response
    localparam logic [1:0] HRESP_OKAY = 2'b00;

    // APB slave windows, one 64 MB region each, selected by address bits [31:26]
    localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
    localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
    localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
    localparam logic [31:0] SLV3_BASE = 32'h8C00_0000;
    localparam int          REGION_W  = 6;

    // Range that the bridge accepts; slave 3 is decoded but lies outside it
    localparam logic [31:0] VALID_LO = 32'h8000_0000;
    localparam logic [31:0] VALID_HI = 32'h8BFF_FFFF;

    // Region tag (top address bits) of slave idx
    function automatic logic [REGION_W-1:0] slave_region(input int idx);
        logic [31:0] base;
        case (idx)
            0:       base = SLV0_BASE;
            1:       base = SLV1_BASE;
            2:       base = SLV2_BASE;
            3:       base = SLV3_BASE;
            default: base = 32'hFFFF_FFFF;
        endcase
        return base[31 -: REGION_W];
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational AHB address to one-hot APB select decoder
//   addr  : AHB address
//   sel   : one-hot slave select (decoded regardless of the accepted range)
//   valid : address lies in the accepted range and hits a slave
module apb_addr_decoder
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NSEL   = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NSEL-1:0]   sel,
    output logic              valid
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NSEL; i++) begin
            if (addr[ADDR_W-1 -: REGION_W] == slave_region(i)) begin
                sel[i] = 1'b1;
            end
        end
        valid = (addr >= ADDR_W'(VALID_LO)) && (addr <= ADDR_W'(VALID_HI)) && (|sel);
    end

endmodule

// File: rtl/modport_bridge.sv
// rtl/modport_bridge.sv - non-pipelined AHB-Lite slave to APB master bridge
//   AHB side : Hclk, Hreset, Hwrite, Hreadyin, Htrans, Haddr, Hwdata -> Hrdata, Hreadyout, Hresp
//   APB side : Prdata -> Pselx, Pwrite, Penable, Paddr, Pwdata
module modport_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 4
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    output logic [DATA_W-1:0] Hrdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    input  logic [DATA_W-1:0] Prdata,
    output logic [NSEL-1:0]   Pselx,
    output logic              Pwrite,
    output logic              Penable,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata
);

    state_t            state, state_next;
    logic [NSEL-1:0]   dec_sel;
    logic              dec_valid;
    logic              xfer_valid;
    logic              capture;
    logic [ADDR_W-1:0] haddr_q;
    logic              hwrite_q;
    logic [NSEL-1:0]   sel_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              apb_active;

    apb_addr_decoder #(
        .ADDR_W (ADDR_W),
        .NSEL   (NSEL)
    ) u_dec (
        .addr  (Haddr),
        .sel   (dec_sel),
        .valid (dec_valid)
    );

    assign xfer_valid = Hreadyin && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ) && dec_valid;

    // New address phases are only accepted while Hreadyout is high:
    // in idle and in the final (enable) cycle of an APB access.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE, ST_WENABLE, ST_RENABLE: begin
                if (xfer_valid) begin
                    capture    = 1'b1;
                    state_next = Hwrite ? ST_WWAIT : ST_READ;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WWAIT: state_next = ST_WRITE;
            ST_WRITE: state_next = ST_WENABLE;
            ST_READ:  state_next = ST_RENABLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state    <= ST_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            sel_q    <= '0;
            pwdata_q <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                haddr_q  <= Haddr;
                hwrite_q <= Hwrite;
                sel_q    <= dec_sel;
            end
            // Write data arrives in the AHB data phase, one cycle after the address
            if (state == ST_WWAIT) begin
                pwdata_q <= Hwdata;
            end
        end
    end

    // Outputs decode from state so that an asynchronous reset clears them at once
    assign apb_active = (state == ST_WRITE) || (state == ST_WENABLE) ||
                        (state == ST_READ)  || (state == ST_RENABLE);

    assign Pselx     = apb_active ? sel_q : '0;
    assign Penable   = (state == ST_WENABLE) || (state == ST_RENABLE);
    assign Pwrite    = apb_active && hwrite_q;
    assign Paddr     = haddr_q;
    assign Pwdata    = pwdata_q;
    assign Hrdata    = (state == ST_RENABLE) ? Prdata : '0;
    assign Hreadyout = !((state == ST_WWAIT) || (state == ST_WRITE) || (state == ST_READ));
    assign Hresp     = HRESP_OKAY;

endmodule

// File: tb/tb_modport_bridge.sv
// tb/tb_modport_bridge.sv - directed self-checking bench for modport_bridge
module tb_modport_bridge;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Hrdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Prdata;
    logic [3:0]  Pselx;
    logic        Pwrite;
    logic        Penable;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;

    int checks = 0;
    int errors = 0;

    modport_bridge #(.ADDR_W(32), .DATA_W(32), .NSEL(4)) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hrdata    (Hrdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Prdata    (Prdata),
        .Pselx     (Pselx),
        .Pwrite    (Pwrite),
        .Penable   (Penable),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Hclk);
        #1;
    endtask

    task automatic ahb(input logic [1:0] tr, input logic wr, input logic [31:0] a);
        Htrans   = tr;
        Hwrite   = wr;
        Haddr    = a;
        Hreadyin = 1'b1;
    endtask

    logic [31:0] sweep_addr [3];
    logic [3:0]  sweep_sel  [3];
    logic [1:0]  ign_trans  [4];
    logic        ign_ready  [4];
    logic [31:0] ign_addr   [4];

    initial begin
        sweep_addr = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000};
        sweep_sel  = '{4'b0001, 4'b0010, 4'b0100};
        ign_trans  = '{2'b00, 2'b01, 2'b10, 2'b10};
        ign_ready  = '{1'b1, 1'b1, 1'b0, 1'b1};
        ign_addr   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h9000_0000};

        Hreset = 1'b1;
        Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00;
        Haddr = '0; Hwdata = '0; Prdata = '0;
        cyc(); cyc();

        // Reset state
        chk("rst_pselx",   32'(Pselx),     32'h0);
        chk("rst_penable", 32'(Penable),   32'h0);
        chk("rst_pwrite",  32'(Pwrite),    32'h0);
        chk("rst_paddr",   Paddr,          32'h0);
        chk("rst_pwdata",  Pwdata,         32'h0);
        chk("rst_hrdata",  Hrdata,         32'h0);
        chk("rst_hready",  32'(Hreadyout), 32'h1);
        chk("rst_hresp",   32'(Hresp),     32'h0);
        Hreset = 1'b0;
        cyc();

        // Single read
        ahb(2'b10, 1'b0, 32'h8000_0010);
        Prdata = 32'hDEAD_BEEF;
        cyc();
        Htrans = 2'b00;
        chk("rd_setup_pselx",   32'(Pselx),     32'h1);
        chk("rd_setup_penable", 32'(Penable),   32'h0);
        chk("rd_setup_paddr",   Paddr,          32'h8000_0010);
        chk("rd_setup_pwrite",  32'(Pwrite),    32'h0);
        chk("rd_setup_hready",  32'(Hreadyout), 32'h0);
        chk("rd_setup_hrdata",  Hrdata,         32'h0);
        cyc();
        chk("rd_en_penable", 32'(Penable),   32'h1);
        chk("rd_en_pselx",   32'(Pselx),     32'h1);
        chk("rd_en_hrdata",  Hrdata,         32'hDEAD_BEEF);
        chk("rd_en_hready",  32'(Hreadyout), 32'h1);
        cyc();
        chk("rd_done_pselx",  32'(Pselx), 32'h0);
        chk("rd_done_hrdata", Hrdata,     32'h0);

        // Single write
        ahb(2'b10, 1'b1, 32'h8400_0004);
        cyc();
        Htrans = 2'b00;
        Hwdata = 32'h1234_5678;
        chk("wr_wait_hready", 32'(Hreadyout), 32'h0);
        chk("wr_wait_pselx",  32'(Pselx),     32'h0);
        cyc();
        Hwdata = 32'h0;
        chk("wr_setup_pselx",   32'(Pselx),     32'h2);
        chk("wr_setup_pwrite",  32'(Pwrite),    32'h1);
        chk("wr_setup_penable", 32'(Penable),   32'h0);
        chk("wr_setup_pwdata",  Pwdata,         32'h1234_5678);
        chk("wr_setup_paddr",   Paddr,          32'h8400_0004);
        chk("wr_setup_hready",  32'(Hreadyout), 32'h0);
        cyc();
        chk("wr_en_penable", 32'(Penable),   32'h1);
        chk("wr_en_pselx",   32'(Pselx),     32'h2);
        chk("wr_en_hready",  32'(Hreadyout), 32'h1);
        cyc();
        chk("wr_done_pselx",   32'(Pselx),   32'h0);
        chk("wr_done_penable", 32'(Penable), 32'h0);

        // Decode sweep
        for (int i = 0; i < 3; i++) begin
            ahb(2'b10, 1'b0, sweep_addr[i]);
            cyc();
            Htrans = 2'b00;
            chk($sformatf("sweep%0d_pselx", i), 32'(Pselx), 32'(sweep_sel[i]));
            cyc(); cyc();
        end

        // Ignored transfers
        for (int i = 0; i < 4; i++) begin
            Htrans = ign_trans[i]; Hreadyin = ign_ready[i];
            Haddr = ign_addr[i]; Hwrite = 1'b0;
            cyc();
            chk($sformatf("ign%0d_pselx",  i), 32'(Pselx),     32'h0);
            chk($sformatf("ign%0d_hready", i), 32'(Hreadyout), 32'h1);
            cyc();
            chk($sformatf("ign%0d_pselx2", i), 32'(Pselx),     32'h0);
        end
        Htrans = 2'b00; Hreadyin = 1'b1;

        // Back-to-back: write, then SEQ read presented in the write's enable cycle
        ahb(2'b10, 1'b1, 32'h8800_0008);
        cyc();
        Htrans = 2'b00;
        Hwdata = 32'hCAFE_F00D;
        chk("b2b_wait_hresp", 32'(Hresp), 32'h0);
        cyc();
        chk("b2b_wsetup_pselx", 32'(Pselx), 32'h4);
        cyc();
        ahb(2'b11, 1'b0, 32'h8000_0020);
        Prdata = 32'h0BAD_F00D;
        chk("b2b_wen_penable", 32'(Penable), 32'h1);
        chk("b2b_wen_pselx",   32'(Pselx),   32'h4);
        chk("b2b_wen_pwdata",  Pwdata,       32'hCAFE_F00D);
        chk("b2b_wen_hresp",   32'(Hresp),   32'h0);
        cyc();
        Htrans = 2'b00;
        chk("b2b_rd_pselx",   32'(Pselx),     32'h1);
        chk("b2b_rd_penable", 32'(Penable),   32'h0);
        chk("b2b_rd_paddr",   Paddr,          32'h8000_0020);
        chk("b2b_rd_hready",  32'(Hreadyout), 32'h0);
        chk("b2b_rd_hresp",   32'(Hresp),     32'h0);
        cyc();
        chk("b2b_ren_hrdata", Hrdata,       32'h0BAD_F00D);
        chk("b2b_ren_hresp",  32'(Hresp),   32'h0);
        cyc();

        // Reset in the middle of a write (during APB SETUP)
        ahb(2'b10, 1'b1, 32'h8400_0000);
        cyc();
        Htrans = 2'b00;
        Hwdata = 32'h5555_AAAA;
        cyc();
        chk("mid_setup_pselx", 32'(Pselx), 32'h2);
        Hreset = 1'b1;
        #1;
        chk("mid_rst_pselx",   32'(Pselx),     32'h0);
        chk("mid_rst_penable", 32'(Penable),   32'h0);
        chk("mid_rst_hready",  32'(Hreadyout), 32'h1);
        chk("mid_rst_paddr",   Paddr,          32'h0);
        cyc();
        Hreset = 1'b0;
        cyc();
        chk("post_rst_pselx",   32'(Pselx),     32'h0);
        chk("post_rst_penable", 32'(Penable),   32'h0);
        chk("post_rst_hready",  32'(Hreadyout), 32'h1);
        cyc();
        chk("post_rst_idle_pselx", 32'(Pselx), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modport_bridge.md
Name: modport_bridge

Overview:
AHB-Lite slave to APB master bridge; non-pipelined, one APB transfer per AHB transfer.
- Sits between the AHB interconnect and four APB peripherals on the APB bus interface (Prdata, Pselx, Pwrite, Penable, Paddr, Pwdata).
- Decodes the AHB address into a one-hot Pselx.
- Sequences the APB SETUP/ENABLE phases.
- Stalls AHB via Hreadyout until the APB access completes.

Parameters:
- ADDR_W, 32, AHB/APB address width
- DATA_W, 32, data width
- NSEL, 4, number of APB slave selects

Ports:
- Hclk  in  1  bus clock, all state on posedge
- Hreset  in  1  asynchronous, active-high reset
- Hwrite  in  1  AHB write (1) / read (0)
- Hreadyin  in  1  AHB ready from the interconnect
- Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- Haddr  in  32  AHB address
- Hwdata  in  32  AHB write data (data phase)
- Hrdata  out  32  AHB read data
- Hreadyout  out  1  AHB ready to master
- Hresp  out  2  AHB response
- Prdata  in  32  APB read data
- Pselx  out  4  one-hot APB slave select
- Pwrite  out  1  APB direction
- Penable  out  1  APB enable
- Paddr  out  32  APB address
- Pwdata  out  32  APB write data

Behaviour:
- Reset: immediate on Hreset=1. Outputs after reset: Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hrdata=0, Hreadyout=1, Hresp=00. FSM goes to ST_IDLE.
- Reset mid-transfer aborts the APB access at once; no completion is signalled.
- Valid transfer: Hreadyin=1, Htrans in {10, 11}, Haddr in 0x8000_0000..0x8BFF_FFFF.
  - BUSY and IDLE transfers are ignored.
  - Out-of-range addresses are ignored: no Pselx, Hreadyout stays 1, Hresp=OKAY.
- Decode on Haddr[31:26]:
  - 0x8000_0000..0x83FF_FFFF -> 0001
  - 0x8400_0000..0x87FF_FFFF -> 0010
  - 0x8800_0000..0x8BFF_FFFF -> 0100
  - 0x8C00_0000..0x8FFF_FFFF -> 1000 (slave 3 is reachable only if the valid range is widened; it stays decoded)
- Address phase capture: on a valid cycle the bridge registers Haddr, Hwrite and the select.
- FSM states: ST_IDLE, ST_WWAIT, ST_WRITE, ST_WENABLE, ST_READ, ST_RENABLE.
  - ST_IDLE: valid read -> ST_READ; valid write -> ST_WWAIT; else stay.
  - ST_WWAIT: Hwdata captured into Pwdata; Hreadyout=0; -> ST_WRITE.
  - ST_WRITE (APB SETUP): Pselx=decoded, Penable=0, Pwrite=1, Paddr/Pwdata valid; Hreadyout=0; -> ST_WENABLE.
  - ST_WENABLE: Penable=1, Pselx held; Hreadyout=1; -> ST_IDLE, or directly to ST_READ/ST_WWAIT if a new valid transfer is presented this cycle (back-to-back).
  - ST_READ (SETUP): Pselx=decoded, Penable=0, Pwrite=0; Hreadyout=0; -> ST_RENABLE.
  - ST_RENABLE: Penable=1; Hrdata=Prdata (combinational pass-through); Hreadyout=1; same exit as ST_WENABLE.
- Latency, from the valid address-phase edge:
  - Read: 2 cycles; Pselx asserted cycle+1, Penable cycle+2.
  - Write: 3 cycles.
- Hresp is always 00 (OKAY). APB has no PREADY/PSLVERR; zero wait states.
- Outside the enable states, Hrdata holds 0.
- Pselx is all-zero whenever the FSM is in ST_IDLE or ST_WWAIT.

Decomposition:
- Package ahb_apb_pkg holds:
  - state enum
  - HTRANS constants (IDLE, BUSY, NONSEQ, SEQ)
  - HRESP_OKAY
  - slave base-address constants
- Sub-module apb_addr_decoder: combinational Haddr -> one-hot Pselx plus valid flag.
- The FSM and data path live in the top module.

Test Plan:
- Reset: assert Hreset mid-write (during ST_WRITE) -> same cycle Pselx=0, Penable=0, Hreadyout=1; after release the FSM is idle.
- Single read: Haddr=0x8000_0010, Htrans=10, Hwrite=0, Prdata=0xDEAD_BEEF -> cycle+1 Pselx=0001, Penable=0, Paddr=0x8000_0010; cycle+2 Penable=1, Hrdata=0xDEAD_BEEF, Hreadyout=1.
- Single write: Haddr=0x8400_0004, Hwdata=0x1234_5678 -> Pselx=0010, Pwrite=1, Pwdata=0x1234_5678; Penable rises one cycle after Pselx; Hreadyout low for 2 cycles.
- Decode sweep: reads to 0x8000_0000, 0x8400_0000, 0x8800_0000 -> Pselx 0001, 0010, 0100.
- Ignored transfers: Htrans=00/01, Hreadyin=0, or Haddr=0x9000_0000 -> Pselx stays 0, Hreadyout stays 1.
- Back-to-back: a SEQ read presented during ST_WENABLE of a write -> next cycle ST_READ with no idle cycle; Hresp=00 throughout.
